// File: rtl/tow_pkg.sv
// Shared constants for the Tug-of-War scorer: LED display codes used by the
// master controller and the round-state encoding of the round arbiter.
package tow_pkg;

  typedef logic [1:0] led_code_t;
  typedef logic [1:0] round_state_t;

  localparam led_code_t LED_ALL_OFF    = 2'd0;
  localparam led_code_t LED_ALL_ON     = 2'd1;
  localparam led_code_t LED_RESET_CODE = 2'd2;
  localparam led_code_t LED_SCORE      = 2'd3;

  localparam round_state_t ST_ARMED      = 2'd0;
  localparam round_state_t ST_DECIDED    = 2'd1;
  localparam round_state_t ST_MATCH_DONE = 2'd2;

endpackage

// File: rtl/tow_scorer_if.sv
// Bundle between the master controller / player buttons and the scorer,
// with debug visibility of the round state and rope position.
interface tow_scorer_if #(
  parameter int N_LEDS = 7
);
  import tow_pkg::*;

  localparam int PW = $clog2(N_LEDS);

  // No valid/ready handshake here: pbl/pbr are single-cycle pulses that are
  // consumed or dropped in the cycle they arrive, and every scorer output is a
  // level that holds until the controller acts (winrnd holds until clear).
  logic              pbl;
  logic              pbr;
  logic              leds_on;
  led_code_t         leds_ctrl;
  logic              clear;
  logic [N_LEDS-1:0] leds;
  logic              winrnd;
  logic              match_over;
  logic              winner;
  round_state_t      dbg_state;
  logic [PW-1:0]     dbg_pos;

  modport master (
    output pbl, pbr, leds_on, leds_ctrl, clear,
    input  leds, winrnd, match_over, winner, dbg_state, dbg_pos
  );

  modport slave (
    input  pbl, pbr, leds_on, leds_ctrl, clear,
    output leds, winrnd, match_over, winner, dbg_state, dbg_pos
  );

endinterface

// File: rtl/tow_round_arbiter.sv
// Round FSM: judges pushes (false start in the dark, first push in play) and
// emits single-cycle award/void pulses plus the held winrnd level.
module tow_round_arbiter
  import tow_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         pbl,
  input  logic         pbr,
  input  logic         leds_on,
  input  logic         clear,
  input  logic         at_left_end,
  input  logic         at_right_end,
  output logic         award_l,
  output logic         award_r,
  output logic         void_rnd,
  output logic         winrnd,
  output round_state_t state
);

  logic decided;
  logic terminal;

  // In the dark a push is a false start, so the opponent takes the round.
  always_comb begin
    award_l  = 1'b0;
    award_r  = 1'b0;
    void_rnd = 1'b0;
    if (state == ST_ARMED && !clear) begin
      if (pbl && pbr) begin
        void_rnd = 1'b1;
      end else if (leds_on) begin
        award_l = pbl;
        award_r = pbr;
      end else begin
        award_l = pbr;
        award_r = pbl;
      end
    end
  end

  assign decided  = award_l | award_r | void_rnd;
  assign terminal = (award_l & at_left_end) | (award_r & at_right_end);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_ARMED;
      winrnd <= 1'b0;
    end else begin
      case (state)
        ST_ARMED: begin
          if (terminal) begin
            state  <= ST_MATCH_DONE;
            winrnd <= 1'b1;
          end else if (decided) begin
            state  <= ST_DECIDED;
            winrnd <= 1'b1;
          end
        end
        ST_DECIDED: begin
          if (clear) begin
            state  <= ST_ARMED;
            winrnd <= 1'b0;
          end
        end
        ST_MATCH_DONE: begin
          if (clear) winrnd <= 1'b0;
        end
        default: begin
          state  <= ST_ARMED;
          winrnd <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/tow_scorer.sv
// Tug-of-War scorer: holds the rope position and match result, and drives the
// registered LED bank from the controller's display code.
module tow_scorer
  import tow_pkg::*;
#(
  parameter int N_LEDS = 7
) (
  input  logic         clk,
  input  logic         rst,
  tow_scorer_if.slave  bus
);

  localparam int PW     = $clog2(N_LEDS);
  localparam int CENTRE = (N_LEDS - 1) / 2;

  logic [PW-1:0]     pos;
  logic              match_over;
  logic              winner;
  logic [N_LEDS-1:0] leds_q;
  logic [N_LEDS-1:0] leds_next;
  logic              at_left_end;
  logic              at_right_end;
  logic              award_l;
  logic              award_r;
  logic              void_rnd;
  logic              winrnd;
  round_state_t      state;

  assign at_left_end  = (pos == PW'(N_LEDS - 1));
  assign at_right_end = (pos == '0);

  tow_round_arbiter u_arbiter (
    .clk          (clk),
    .rst          (rst),
    .pbl          (bus.pbl),
    .pbr          (bus.pbr),
    .leds_on      (bus.leds_on),
    .clear        (bus.clear),
    .at_left_end  (at_left_end),
    .at_right_end (at_right_end),
    .award_l      (award_l),
    .award_r      (award_r),
    .void_rnd     (void_rnd),
    .winrnd       (winrnd),
    .state        (state)
  );

  // An award at a terminal position ends the match instead of moving the rope.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos        <= PW'(CENTRE);
      match_over <= 1'b0;
      winner     <= 1'b0;
    end else if (award_l) begin
      if (at_left_end) begin
        match_over <= 1'b1;
        winner     <= 1'b1;
      end else begin
        pos <= pos + PW'(1);
      end
    end else if (award_r) begin
      if (at_right_end) begin
        match_over <= 1'b1;
        winner     <= 1'b0;
      end else begin
        pos <= pos - PW'(1);
      end
    end
  end

  always_comb begin
    leds_next = '0;
    if (bus.leds_on) begin
      case (bus.leds_ctrl)
        LED_ALL_ON: leds_next = '1;
        LED_RESET_CODE: begin
          for (int i = 0; i < N_LEDS; i++) leds_next[i] = ((i % 2) == 0);
        end
        LED_SCORE: begin
          if (match_over) begin
            for (int i = 0; i < N_LEDS; i++)
              leds_next[i] = winner ? (i >= CENTRE) : (i <= CENTRE);
          end else begin
            leds_next[pos] = 1'b1;
          end
        end
        default: leds_next = '0;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) leds_q <= '0;
    else     leds_q <= leds_next;
  end

  assign bus.leds       = leds_q;
  assign bus.winrnd     = winrnd;
  assign bus.match_over = match_over;
  assign bus.winner     = winner;
  assign bus.dbg_state  = state;
  assign bus.dbg_pos    = pos;

  // void_rnd only matters inside the arbiter (it sets winrnd, not pos).
  logic unused_void;
  assign unused_void = void_rnd;

endmodule

// File: tb/tb_tow_scorer.sv
// Directed bench for tow_scorer: hand-computed expectations for reset, play,
// dark false starts, void rounds, match end on both sides and async reset.
module tb_tow_scorer;
  import tow_pkg::*;

  localparam int N_LEDS = 7;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  tow_scorer_if #(.N_LEDS(N_LEDS)) bus ();

  tow_scorer #(.N_LEDS(N_LEDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h @%0t", tag, obs, exp, $time);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic push(input logic l, input logic r);
    bus.pbl = l;
    bus.pbr = r;
    tick();
    bus.pbl = 1'b0;
    bus.pbr = 1'b0;
  endtask

  task automatic set_phase(input logic on, input led_code_t code, input logic clr);
    bus.leds_on   = on;
    bus.leds_ctrl = code;
    bus.clear     = clr;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst   = 1'b1;
    bus.pbl = 1'b0;
    bus.pbr = 1'b0;
    set_phase(1'b1, LED_SCORE, 1'b1);

    // reset values
    tick();
    check_eq("rst_leds", 32'(bus.leds), 32'h00);
    check_eq("rst_winrnd", 32'(bus.winrnd), 32'd0);
    check_eq("rst_match", 32'(bus.match_over), 32'd0);
    check_eq("rst_winner", 32'(bus.winner), 32'd0);
    check_eq("rst_pos", 32'(bus.dbg_pos), 32'd3);
    rst = 1'b0;
    tick();
    check_eq("idle_leds", 32'(bus.leds), 32'b0001000);
    check_eq("idle_state", 32'(bus.dbg_state), 32'(ST_ARMED));

    // play: left push, ignored follow-up, then clear
    bus.clear = 1'b0;
    push(1'b1, 1'b0);
    check_eq("play_l_winrnd", 32'(bus.winrnd), 32'd1);
    check_eq("play_l_pos", 32'(bus.dbg_pos), 32'd4);
    tick();
    check_eq("play_l_leds", 32'(bus.leds), 32'b0010000);
    push(1'b0, 1'b1);
    check_eq("decided_ignore_pos", 32'(bus.dbg_pos), 32'd4);
    check_eq("decided_ignore_winrnd", 32'(bus.winrnd), 32'd1);
    bus.clear = 1'b1;
    tick();
    check_eq("clear_winrnd", 32'(bus.winrnd), 32'd0);
    check_eq("clear_state", 32'(bus.dbg_state), 32'(ST_ARMED));

    // dark: right false start awards left, left false start awards right
    do_reset();
    set_phase(1'b0, LED_ALL_OFF, 1'b0);
    push(1'b0, 1'b1);
    check_eq("dark_r_pos", 32'(bus.dbg_pos), 32'd4);
    check_eq("dark_r_winrnd", 32'(bus.winrnd), 32'd1);
    tick();
    check_eq("dark_leds", 32'(bus.leds), 32'h00);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    push(1'b1, 1'b0);
    check_eq("dark_l_pos", 32'(bus.dbg_pos), 32'd3);
    check_eq("dark_l_winrnd", 32'(bus.winrnd), 32'd1);

    // void round, clear dominating a push, then a right award in play
    do_reset();
    set_phase(1'b1, LED_SCORE, 1'b0);
    push(1'b1, 1'b1);
    check_eq("void_winrnd", 32'(bus.winrnd), 32'd1);
    check_eq("void_pos", 32'(bus.dbg_pos), 32'd3);
    bus.clear = 1'b1;
    tick();
    push(1'b1, 1'b0);
    check_eq("clr_push_winrnd", 32'(bus.winrnd), 32'd0);
    check_eq("clr_push_pos", 32'(bus.dbg_pos), 32'd3);
    bus.clear = 1'b0;
    push(1'b0, 1'b1);
    check_eq("play_r_pos", 32'(bus.dbg_pos), 32'd2);
    tick();
    check_eq("play_r_leds", 32'(bus.leds), 32'b0000100);

    // left wins the match: pos 4,5,6 then a terminal award
    do_reset();
    set_phase(1'b1, LED_SCORE, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      bus.clear = 1'b0;
      push(1'b1, 1'b0);
      check_eq("lmatch_winrnd", 32'(bus.winrnd), 32'd1);
      check_eq("lmatch_pos", 32'(bus.dbg_pos), 32'((k < 4) ? 3 + k : 6));
      check_eq("lmatch_over", 32'(bus.match_over), 32'((k == 4) ? 1 : 0));
      bus.clear = 1'b1;
      tick();
      check_eq("lmatch_clear", 32'(bus.winrnd), 32'd0);
    end
    check_eq("lmatch_winner", 32'(bus.winner), 32'd1);
    check_eq("lmatch_state", 32'(bus.dbg_state), 32'(ST_MATCH_DONE));
    check_eq("lmatch_leds", 32'(bus.leds), 32'b1111000);
    bus.clear = 1'b0;
    push(1'b0, 1'b1);
    check_eq("done_ignore_winrnd", 32'(bus.winrnd), 32'd0);
    check_eq("done_ignore_pos", 32'(bus.dbg_pos), 32'd6);
    check_eq("done_ignore_over", 32'(bus.match_over), 32'd1);

    // right wins the match through dark false starts
    do_reset();
    set_phase(1'b0, LED_ALL_OFF, 1'b0);
    for (int k = 1; k <= 4; k++) begin
      bus.clear = 1'b0;
      push(1'b1, 1'b0);
      check_eq("rmatch_pos", 32'(bus.dbg_pos), 32'((k < 4) ? 3 - k : 0));
      bus.clear = 1'b1;
      tick();
    end
    check_eq("rmatch_over", 32'(bus.match_over), 32'd1);
    check_eq("rmatch_winner", 32'(bus.winner), 32'd0);
    set_phase(1'b1, LED_SCORE, 1'b1);
    tick();
    check_eq("rmatch_leds", 32'(bus.leds), 32'b0001111);

    // asynchronous reset mid-play
    do_reset();
    set_phase(1'b1, LED_SCORE, 1'b0);
    push(1'b1, 1'b0);
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    push(1'b1, 1'b0);
    tick();
    check_eq("pre_rst_pos", 32'(bus.dbg_pos), 32'd5);
    check_eq("pre_rst_winrnd", 32'(bus.winrnd), 32'd1);
    check_eq("pre_rst_leds", 32'(bus.leds), 32'b0100000);
    #2 rst = 1'b1;
    #1;
    check_eq("async_rst_leds", 32'(bus.leds), 32'h00);
    check_eq("async_rst_winrnd", 32'(bus.winrnd), 32'd0);
    check_eq("async_rst_pos", 32'(bus.dbg_pos), 32'd3);
    #1 rst = 1'b0;
    set_phase(1'b1, LED_RESET_CODE, 1'b1);
    tick();
    check_eq("reset_code_leds", 32'(bus.leds), 32'b1010101);
    set_phase(1'b1, LED_ALL_ON, 1'b1);
    tick();
    check_eq("all_on_leds", 32'(bus.leds), 32'b1111111);

    // final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
